// File: rtl/keypad_code_sender_pkg.sv
// Definitions shared between the keypad code sender and the door lock:
// sender FSM state names and the default code width both sides must agree on.
package door_lock_pkg;

  localparam int CODE_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COLLECT   = 3'd1,
    SUBMIT    = 3'd2,
    WAIT_RESP = 3'd3,
    LOCKOUT   = 3'd4
  } sender_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_code_sender_if.sv
// Keypad/lock-side signal bundle of the code sender. The sender is the master;
// keypad front end and lock responder together form the slave side.
interface keypad_code_sender_if #(
  parameter int CODE_W    = door_lock_pkg::CODE_W_DEFAULT,
  parameter int MAX_FAILS = 3
);

  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  logic              key_valid;
  logic              key_bit;
  logic              key_clear;
  logic              door_unlock;
  logic              error;
  logic [CODE_W-1:0] code_out;
  logic              submit;
  logic              busy;
  logic              granted;
  logic              denied;
  logic              timeout;
  logic              locked_out;
  logic [FAIL_W-1:0] fail_cnt;

  modport master (
    input  key_valid,
    input  key_bit,
    input  key_clear,
    input  door_unlock,
    input  error,
    output code_out,
    output submit,
    output busy,
    output granted,
    output denied,
    output timeout,
    output locked_out,
    output fail_cnt
  );

  modport slave (
    output key_valid,
    output key_bit,
    output key_clear,
    output door_unlock,
    output error,
    input  code_out,
    input  submit,
    input  busy,
    input  granted,
    input  denied,
    input  timeout,
    input  locked_out,
    input  fail_cnt
  );

endinterface

// File: rtl/keypad_code_sender_timer.sv
// Loadable down-counter shared by the response timeout and the lockout duration.
// expired flags the last enabled cycle of a window (count at zero).
module door_cycle_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  output logic             expired
);

  logic [WIDTH-1:0] count_r;

  // Load wins over counting; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_value;
    end else if (count_en && (count_r != '0)) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = count_en && (count_r == '0);

endmodule

// File: rtl/keypad_code_sender.sv
// Door-lock code initiator: collects a bit-serial keypad code, submits it to the
// lock, tracks the response, counts consecutive failures and enforces a lockout.
module keypad_code_sender
  import door_lock_pkg::*;
#(
  parameter int CODE_W         = CODE_W_DEFAULT,
  parameter int MAX_FAILS      = 3,
  parameter int RESP_TIMEOUT   = 8,
  parameter int LOCKOUT_CYCLES = 64
) (
  input logic                  clk,
  input logic                  rst,
  keypad_code_sender_if.master bus
);

  localparam int FAIL_W    = $clog2(MAX_FAILS + 1);
  localparam int BIT_CNT_W = $clog2(CODE_W + 1);
  localparam int TIMER_MAX = max_int(RESP_TIMEOUT, LOCKOUT_CYCLES);
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_COLLECT = COLLECT;
  localparam logic [2:0] S_SUBMIT  = SUBMIT;
  localparam logic [2:0] S_WAIT    = WAIT_RESP;
  localparam logic [2:0] S_LOCKOUT = LOCKOUT;

  logic [2:0]           state_r;
  logic [CODE_W-1:0]    shreg_r;
  logic [BIT_CNT_W-1:0] bit_cnt_r;
  logic [CODE_W-1:0]    code_r;
  logic                 submit_r;
  logic                 busy_r;
  logic                 granted_r;
  logic                 denied_r;
  logic                 timeout_r;
  logic                 locked_r;
  logic [FAIL_W-1:0]    fail_r;

  logic [2:0]           state_s;
  logic [CODE_W-1:0]    shreg_s;
  logic [CODE_W-1:0]    shifted_s;
  logic [BIT_CNT_W-1:0] bit_cnt_s;
  logic [CODE_W-1:0]    code_s;
  logic                 submit_s;
  logic                 granted_s;
  logic                 denied_s;
  logic                 timeout_s;
  logic [FAIL_W-1:0]    fail_s;
  logic [FAIL_W-1:0]    fail_inc_s;
  logic                 tmr_load_s;
  logic [TIMER_W-1:0]   tmr_value_s;
  logic                 tmr_en_s;
  logic                 tmr_expired_s;

  door_cycle_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load_s),
    .load_value (tmr_value_s),
    .count_en   (tmr_en_s),
    .expired    (tmr_expired_s)
  );

  assign shifted_s  = (shreg_r << 1) | CODE_W'(bus.key_bit);
  assign fail_inc_s = (fail_r >= FAIL_W'(MAX_FAILS)) ? fail_r : (fail_r + FAIL_W'(1));

  // Next-state and next-output logic for the sender FSM.
  always_comb begin
    state_s     = state_r;
    shreg_s     = shreg_r;
    bit_cnt_s   = bit_cnt_r;
    code_s      = code_r;
    submit_s    = 1'b0;
    granted_s   = 1'b0;
    denied_s    = 1'b0;
    timeout_s   = 1'b0;
    fail_s      = fail_r;
    tmr_load_s  = 1'b0;
    tmr_value_s = '0;
    tmr_en_s    = 1'b0;

    case (state_r)
      S_IDLE, S_COLLECT: begin
        // Clear beats a simultaneous key bit; the bit is dropped.
        if (bus.key_clear) begin
          state_s   = S_IDLE;
          shreg_s   = '0;
          bit_cnt_s = '0;
        end else if (bus.key_valid) begin
          if (bit_cnt_r == BIT_CNT_W'(CODE_W - 1)) begin
            code_s    = shifted_s;
            submit_s  = 1'b1;
            state_s   = S_SUBMIT;
            shreg_s   = '0;
            bit_cnt_s = '0;
          end else begin
            shreg_s   = shifted_s;
            bit_cnt_s = bit_cnt_r + BIT_CNT_W'(1);
            state_s   = S_COLLECT;
          end
        end else begin
          state_s = state_r;
        end
      end

      S_SUBMIT: begin
        state_s     = S_WAIT;
        tmr_load_s  = 1'b1;
        tmr_value_s = TIMER_W'(RESP_TIMEOUT - 1);
      end

      S_WAIT: begin
        tmr_en_s = 1'b1;
        // error outranks door_unlock so a conflicting response fails safe.
        if (bus.error) begin
          denied_s = 1'b1;
          fail_s   = fail_inc_s;
        end else if (bus.door_unlock) begin
          granted_s = 1'b1;
          fail_s    = '0;
        end else if (tmr_expired_s) begin
          denied_s  = 1'b1;
          timeout_s = 1'b1;
          fail_s    = fail_inc_s;
        end else begin
          fail_s = fail_r;
        end

        if (granted_s || denied_s) begin
          if (fail_s == FAIL_W'(MAX_FAILS)) begin
            state_s     = S_LOCKOUT;
            tmr_load_s  = 1'b1;
            tmr_value_s = TIMER_W'(LOCKOUT_CYCLES - 1);
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          state_s = S_WAIT;
        end
      end

      S_LOCKOUT: begin
        tmr_en_s = 1'b1;
        if (tmr_expired_s) begin
          state_s = S_IDLE;
          fail_s  = '0;
        end else begin
          state_s = S_LOCKOUT;
        end
      end

      default: begin
        state_s   = S_IDLE;
        shreg_s   = '0;
        bit_cnt_s = '0;
      end
    endcase
  end

  // State and registered outputs; busy/locked_out follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      shreg_r   <= '0;
      bit_cnt_r <= '0;
      code_r    <= '0;
      submit_r  <= 1'b0;
      busy_r    <= 1'b0;
      granted_r <= 1'b0;
      denied_r  <= 1'b0;
      timeout_r <= 1'b0;
      locked_r  <= 1'b0;
      fail_r    <= '0;
    end else begin
      state_r   <= state_s;
      shreg_r   <= shreg_s;
      bit_cnt_r <= bit_cnt_s;
      code_r    <= code_s;
      submit_r  <= submit_s;
      busy_r    <= (state_s == S_SUBMIT) || (state_s == S_WAIT) || (state_s == S_LOCKOUT);
      granted_r <= granted_s;
      denied_r  <= denied_s;
      timeout_r <= timeout_s;
      locked_r  <= (state_s == S_LOCKOUT);
      fail_r    <= fail_s;
    end
  end

  assign bus.code_out   = code_r;
  assign bus.submit     = submit_r;
  assign bus.busy       = busy_r;
  assign bus.granted    = granted_r;
  assign bus.denied     = denied_r;
  assign bus.timeout    = timeout_r;
  assign bus.locked_out = locked_r;
  assign bus.fail_cnt   = fail_r;

endmodule

// File: tb/tb_keypad_code_sender.sv
// Scoreboard bench for keypad_code_sender paired with a behavioural lock (PASSWORD 4'b1110).
module tb_keypad_code_sender;

  localparam int             CW        = 4;
  localparam logic [CW-1:0]  PASSWORD  = 4'b1110;
  localparam int             MAXF      = 3;
  localparam int             LOCK_CYC  = 64;
  localparam int             LAT_GRANT = 3;
  localparam int             LAT_DENY  = 2;
  localparam int             LAT_TMO   = 9;
  localparam int             K_SUBMIT  = 0;
  localparam int             K_GRANT   = 1;
  localparam int             K_DENY    = 2;
  localparam int             K_TMO     = 3;
  localparam int             M_NORMAL  = 0;
  localparam int             M_SILENT  = 1;
  localparam int             M_BOTH    = 2;

  typedef struct {
    int            kind;
    logic [CW-1:0] code;
    int            fails;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_code_sender_if #(.CODE_W(CW), .MAX_FAILS(MAXF)) bus ();

  keypad_code_sender #(
    .CODE_W         (CW),
    .MAX_FAILS      (MAXF),
    .RESP_TIMEOUT   (8),
    .LOCKOUT_CYCLES (LOCK_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   n_checks     = 0;
  int   n_pass       = 0;
  int   model_fails  = 0;
  int   exp_lockouts = 0;
  int   lock_mode    = M_NORMAL;
  int   cyc          = 0;
  int   sub_cyc      = 0;
  int   lo_run       = 0;
  bit   lo_prev      = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a submit or a verdict.
  initial begin : monitor
    exp_t e;
    int   kind;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        lo_run  = 0;
        lo_prev = 1'b0;
      end else begin
        if (bus.submit) begin
          if (q.size() == 0) chk("unexpected_submit", 1, 0);
          else begin
            e = q.pop_front();
            chk("submit_slot", e.kind, K_SUBMIT);
            chk("code_out", int'(bus.code_out), int'(e.code));
            sub_cyc = cyc;
          end
        end
        if (bus.granted || bus.denied || bus.timeout) begin
          kind = bus.granted ? K_GRANT : (bus.timeout ? K_TMO : K_DENY);
          chk("pulse_exclusive", int'((bus.granted && bus.denied) || (bus.timeout && !bus.denied)), 0);
          if (q.size() == 0) chk("unexpected_verdict", kind, -1);
          else begin
            e = q.pop_front();
            chk("verdict_kind", kind, e.kind);
            chk("verdict_fail_cnt", int'(bus.fail_cnt), e.fails);
            chk("verdict_latency", cyc - sub_cyc, e.lat);
          end
        end
        if (bus.locked_out) lo_run++;
        else if (lo_prev) begin
          chk("lockout_length", lo_run, LOCK_CYC);
          chk("fail_cnt_after_lockout", int'(bus.fail_cnt), 0);
          chk("lockout_expected", int'(exp_lockouts > 0), 1);
          if (exp_lockouts > 0) exp_lockouts--;
          lo_run = 0;
        end else lo_run = 0;
        lo_prev = bus.locked_out;
      end
    end
  end

  // Behavioural lock: error one cycle after submit on a wrong code, unlock two cycles after on a match.
  initial begin : lock_model
    int err_due = 0;
    int unl_due = 0;
    bus.error       = 1'b0;
    bus.door_unlock = 1'b0;
    forever begin
      @(negedge clk);
      bus.error       = 1'b0;
      bus.door_unlock = 1'b0;
      if (rst) begin
        err_due = 0;
        unl_due = 0;
      end else begin
        if (err_due > 0) begin
          err_due--;
          if (err_due == 0) bus.error = 1'b1;
        end
        if (unl_due > 0) begin
          unl_due--;
          if (unl_due == 0) bus.door_unlock = 1'b1;
        end
        if (bus.submit) begin
          if (lock_mode == M_NORMAL) begin
            if (bus.code_out == PASSWORD) unl_due = 2;
            else err_due = 1;
          end else if (lock_mode == M_BOTH) begin
            err_due = 1;
            unl_due = 1;
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic b, input logic clr);
    @(negedge clk);
    bus.key_valid = v;
    bus.key_bit   = b;
    bus.key_clear = clr;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_clear = 1'b0;
  endtask

  // Reference model: outcome and failure count from the code, password and lock behaviour.
  task automatic enter_code(input logic [CW-1:0] code, input int mode);
    exp_t e;
    lock_mode = mode;
    e.kind = K_SUBMIT; e.code = code; e.fails = 0; e.lat = 0;
    q.push_back(e);
    if (mode == M_NORMAL && code == PASSWORD) begin
      model_fails = 0;
      e.kind = K_GRANT;
      e.lat  = LAT_GRANT;
    end else begin
      if (model_fails < MAXF) model_fails++;
      e.kind = (mode == M_SILENT) ? K_TMO : K_DENY;
      e.lat  = (mode == M_SILENT) ? LAT_TMO : LAT_DENY;
    end
    e.fails = model_fails;
    q.push_back(e);
    if (model_fails == MAXF) begin
      exp_lockouts++;
      model_fails = 0;
    end
    for (int i = CW - 1; i >= 0; i--) drive(1'b1, code[i], 1'b0);
  endtask

  // Waits out busy; optionally hammers the keypad inputs, which must all be ignored.
  task automatic wait_idle(input bit spam);
    int n = 0;
    while (bus.busy && n < 400) begin
      if (spam) begin
        bus.key_valid = 1'($urandom_range(0, 1));
        bus.key_bit   = 1'($urandom_range(0, 1));
        bus.key_clear = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      n++;
    end
    bus.key_valid = 1'b0;
    bus.key_clear = 1'b0;
    if (n >= 400) chk("busy_bound", n, 0);
    @(negedge clk);
  endtask

  task automatic abort_entry(input int nbits, input bit with_valid);
    for (int i = 0; i < nbits; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    drive(with_valid, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, int'({bus.code_out, bus.submit, bus.busy, bus.granted, bus.denied,
                    bus.timeout, bus.locked_out, bus.fail_cnt}), 0);
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero(name);
    q.delete();
    model_fails  = 0;
    exp_lockouts = 0;
    lock_mode    = M_NORMAL;
    rst = 1'b0;
  endtask

  initial begin : stim
    int n;
    int r;
    logic [CW-1:0] code;
    bus.key_valid = 1'b0;
    bus.key_bit   = 1'b0;
    bus.key_clear = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;

    enter_code(4'b1110, M_NORMAL); wait_idle(1'b0);
    enter_code(4'b1010, M_NORMAL); wait_idle(1'b0);
    chk("fail_cnt_after_deny", int'(bus.fail_cnt), 1);

    enter_code(4'b1110, M_NORMAL); wait_idle(1'b0);
    enter_code(4'b0001, M_NORMAL); wait_idle(1'b0);
    enter_code(4'b0110, M_NORMAL); wait_idle(1'b0);
    enter_code(4'b1111, M_NORMAL); wait_idle(1'b1);

    drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0); drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b1);
    enter_code(4'b1110, M_NORMAL); wait_idle(1'b0);

    enter_code(4'b1110, M_SILENT); wait_idle(1'b0);
    chk("fail_cnt_after_timeout", int'(bus.fail_cnt), 1);
    enter_code(4'b1110, M_BOTH); wait_idle(1'b0);
    chk("fail_cnt_after_conflict", int'(bus.fail_cnt), 2);
    enter_code(4'b1110, M_NORMAL); wait_idle(1'b0);

    enter_code(4'b0011, M_SILENT);
    repeat (3) @(negedge clk);
    pulse_reset("reset_in_wait_resp");
    enter_code(4'b0000, M_NORMAL); wait_idle(1'b0);
    enter_code(4'b0101, M_NORMAL); wait_idle(1'b0);
    enter_code(4'b1001, M_NORMAL);
    n = 0;
    while (!bus.locked_out && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("lockout_bound", n, 0);
    repeat (10) @(negedge clk);
    pulse_reset("reset_in_lockout");
    enter_code(4'b1110, M_NORMAL); wait_idle(1'b0);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 7);
      if (r == 0) abort_entry($urandom_range(1, 3), 1'($urandom_range(0, 1)));
      else begin
        code = ($urandom_range(0, 2) == 0) ? PASSWORD : CW'($urandom_range(0, 15));
        enter_code(code, (r == 1) ? M_SILENT : ((r == 2) ? M_BOTH : M_NORMAL));
        wait_idle(1'($urandom_range(0, 1)));
      end
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    chk("lockouts_accounted", exp_lockouts, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
